// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and the data stage.
// Define ARB_TIMEOUT_EN to bound memory wait time and report timeouts on err_o.
module mem_port_arbiter #(
  parameter int XLEN       = 32,
  parameter int AW         = 32,
  parameter int STREAK_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              if_req_i,
  input  logic [AW-1:0]     if_addr_i,
  output logic              if_ack_o,
  output logic [XLEN-1:0]   if_rdata_o,
  output logic              if_stall_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [AW-1:0]     dm_addr_i,
  input  logic [XLEN-1:0]   dm_wdata_i,
  input  logic [XLEN/8-1:0] dm_wstrb_i,
  output logic              dm_ack_o,
  output logic [XLEN-1:0]   dm_rdata_o,
  output logic              dm_stall_o,
  output logic              err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [AW-1:0]     mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  output logic [XLEN/8-1:0] mem_wstrb_o,
  input  logic              mem_ack_i,
  input  logic [XLEN-1:0]   mem_rdata_i
);

  localparam int SW = $clog2(STREAK_MAX + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_next_s;
  logic [SW-1:0]       streak_r;
  logic                grant_if_s;
  logic                grant_dm_s;
  logic                busy_s;
  logic                done_s;
  logic                timeout_s;

  logic                mem_req_r;
  logic                mem_we_r;
  logic [AW-1:0]       mem_addr_r;
  logic [XLEN-1:0]     mem_wdata_r;
  logic [XLEN/8-1:0]   mem_wstrb_r;
  logic                if_ack_r;
  logic                dm_ack_r;
  logic [XLEN-1:0]     if_rdata_r;
  logic [XLEN-1:0]     dm_rdata_r;

  assign done_s = busy_s & (mem_ack_i | timeout_s);

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_if_s) begin
          state_next_s = BUSY_IF;
        end else if (grant_dm_s) begin
          state_next_s = BUSY_DM;
        end else begin
          state_next_s = IDLE;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (done_s) begin
          state_next_s = RESP;
        end else begin
          state_next_s = state_r;
        end
      end
      RESP:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Output decode: data wins a tie unless fetch has waited STREAK_MAX grants
  always_comb begin
    grant_if_s = 1'b0;
    grant_dm_s = 1'b0;
    busy_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (if_req_i && (!dm_req_i || (streak_r == SW'(STREAK_MAX)))) begin
          grant_if_s = 1'b1;
        end else if (dm_req_i) begin
          grant_dm_s = 1'b1;
        end else begin
          grant_if_s = 1'b0;
        end
      end
      BUSY_IF, BUSY_DM: busy_s = 1'b1;
      default:          busy_s = 1'b0;
    endcase
  end

  // Memory request fields, latched on grant and held through BUSY
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      mem_wstrb_r <= '0;
    end else if (grant_if_s) begin
      mem_req_r   <= 1'b1;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= if_addr_i;
      mem_wdata_r <= '0;
      mem_wstrb_r <= '0;
    end else if (grant_dm_s) begin
      mem_req_r   <= 1'b1;
      mem_we_r    <= dm_we_i;
      mem_addr_r  <= dm_addr_i;
      mem_wdata_r <= dm_wdata_i;
      mem_wstrb_r <= dm_wstrb_i;
    end else if (done_s) begin
      mem_req_r   <= 1'b0;
    end else begin
      mem_req_r   <= mem_req_r;
    end
  end

  // Consecutive data grants taken while a fetch was waiting
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      streak_r <= '0;
    end else if (grant_if_s) begin
      streak_r <= '0;
    end else if (grant_dm_s) begin
      if (!if_req_i) begin
        streak_r <= '0;
      end else if (streak_r != SW'(STREAK_MAX)) begin
        streak_r <= streak_r + SW'(1);
      end else begin
        streak_r <= streak_r;
      end
    end else begin
      streak_r <= streak_r;
    end
  end

  // Registered acks and read data; timed-out or store responses return zero
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      if_ack_r   <= 1'b0;
      dm_ack_r   <= 1'b0;
      if_rdata_r <= '0;
      dm_rdata_r <= '0;
    end else begin
      if_ack_r <= done_s & (state_r == BUSY_IF);
      dm_ack_r <= done_s & (state_r == BUSY_DM);
      if (done_s && (state_r == BUSY_IF)) begin
        if_rdata_r <= mem_ack_i ? mem_rdata_i : '0;
      end else begin
        if_rdata_r <= if_rdata_r;
      end
      if (done_s && (state_r == BUSY_DM)) begin
        dm_rdata_r <= (mem_we_r || !mem_ack_i) ? '0 : mem_rdata_i;
      end else begin
        dm_rdata_r <= dm_rdata_r;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);

  logic [WW-1:0] wait_cnt_r;
  logic          err_r;

  assign timeout_s = busy_s & ~mem_ack_i & (wait_cnt_r == WW'(TIMEOUT - 1));

  // Count BUSY cycles spent without an ack
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wait_cnt_r <= '0;
    end else if (grant_if_s || grant_dm_s) begin
      wait_cnt_r <= '0;
    end else if (busy_s && !mem_ack_i) begin
      wait_cnt_r <= wait_cnt_r + WW'(1);
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // A late ack always beats the timeout, so err only flags ack-less completion
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_r <= 1'b0;
    end else begin
      err_r <= done_s & ~mem_ack_i;
    end
  end

  assign err_o = err_r;
`else
  assign timeout_s = 1'b0;
  assign err_o     = 1'b0;
`endif

  assign mem_req_o   = mem_req_r;
  assign mem_we_o    = mem_we_r;
  assign mem_addr_o  = mem_addr_r;
  assign mem_wdata_o = mem_wdata_r;
  assign mem_wstrb_o = mem_wstrb_r;
  assign if_ack_o    = if_ack_r;
  assign dm_ack_o    = dm_ack_r;
  assign if_rdata_o  = if_rdata_r;
  assign dm_rdata_o  = dm_rdata_r;
  assign if_stall_o  = if_req_i & ~if_ack_r;
  assign dm_stall_o  = dm_req_i & ~dm_ack_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: memory model with configurable wait
// states plus a response scoreboard keyed per requester.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int XLEN = 32;
  localparam int AW   = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              if_req, if_ack, if_stall;
  logic [AW-1:0]     if_addr;
  logic [XLEN-1:0]   if_rdata;
  logic              dm_req, dm_we, dm_ack, dm_stall;
  logic [AW-1:0]     dm_addr;
  logic [XLEN-1:0]   dm_wdata, dm_rdata;
  logic [XLEN/8-1:0] dm_wstrb;
  logic              err;
  logic              mem_req, mem_we, mem_ack;
  logic [AW-1:0]     mem_addr;
  logic [XLEN-1:0]   mem_wdata, mem_rdata;
  logic [XLEN/8-1:0] mem_wstrb;

  int errors = 0;
  int checks = 0;

  logic [XLEN:0]   exp_if_q[$];
  logic [XLEN:0]   exp_dm_q[$];
  logic [AW-1:0]   grant_q[$];
  int              mem_wait = 0;
  bit              mem_hang = 1'b0;
  int              busy_cnt = 0;
  logic [1+AW+XLEN+XLEN/8-1:0] held;
  bit              prev_if_ack = 1'b0;
  bit              prev_dm_ack = 1'b0;

  mem_port_arbiter #(.XLEN(XLEN), .AW(AW), .STREAK_MAX(4), .TIMEOUT(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack),
    .if_rdata_o(if_rdata), .if_stall_o(if_stall),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr),
    .dm_wdata_i(dm_wdata), .dm_wstrb_i(dm_wstrb), .dm_ack_o(dm_ack),
    .dm_rdata_o(dm_rdata), .dm_stall_o(dm_stall), .err_o(err),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_wstrb_o(mem_wstrb),
    .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] rd_of(input logic [AW-1:0] a);
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory model: acks after mem_wait wait cycles, checks fields stay stable
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 32'h5A5A_5A5A;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (busy_cnt == 0) begin
          grant_q.push_back(mem_addr);
          held = {mem_we, mem_addr, mem_wdata, mem_wstrb};
        end else begin
          checks++;
          if ({mem_we, mem_addr, mem_wdata, mem_wstrb} !== held) begin
            errors++;
            $display("FAIL mem_fields_stable: got %h required %h",
                     {mem_we, mem_addr, mem_wdata, mem_wstrb}, held);
          end
        end
        if (!mem_hang && busy_cnt == mem_wait) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_we ? 32'hBAD0_0BAD : rd_of(mem_addr);
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = 32'h5A5A_5A5A;
        end
        busy_cnt++;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h5A5A_5A5A;
        busy_cnt  = 0;
      end
    end
  end

  // Scoreboard: pop the expected {err, rdata} whenever a requester is acked
  initial begin
    logic [XLEN:0] e;
    forever begin
      @(negedge clk);
      if (if_ack) begin
        checks++;
        if (prev_if_ack) begin
          errors++;
          $display("FAIL if_ack_pulse: ack high 2 cycles, required 1");
        end
        checks++;
        if (exp_if_q.size() == 0) begin
          errors++;
          $display("FAIL if_ack_unexpected: got ack, required none");
        end else begin
          e = exp_if_q.pop_front();
          if ({err, if_rdata} !== e) begin
            errors++;
            $display("FAIL if_resp: got err=%b rdata=%h required err=%b rdata=%h",
                     err, if_rdata, e[XLEN], e[XLEN-1:0]);
          end
        end
      end
      if (dm_ack) begin
        checks++;
        if (prev_dm_ack) begin
          errors++;
          $display("FAIL dm_ack_pulse: ack high 2 cycles, required 1");
        end
        checks++;
        if (exp_dm_q.size() == 0) begin
          errors++;
          $display("FAIL dm_ack_unexpected: got ack, required none");
        end else begin
          e = exp_dm_q.pop_front();
          if ({err, dm_rdata} !== e) begin
            errors++;
            $display("FAIL dm_resp: got err=%b rdata=%h required err=%b rdata=%h",
                     err, dm_rdata, e[XLEN], e[XLEN-1:0]);
          end
        end
      end
      prev_if_ack = if_ack;
      prev_dm_ack = dm_ack;
    end
  end

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (mem_req !== 1'b0) begin
      errors++; $display("FAIL reset_mem_req: got %b required 0", mem_req);
    end
    checks++;
    if ({mem_we, mem_addr, mem_wdata, mem_wstrb} !== '0) begin
      errors++; $display("FAIL reset_mem_fields: got %h required 0",
                         {mem_we, mem_addr, mem_wdata, mem_wstrb});
    end
    checks++;
    if ({if_ack, dm_ack, err} !== 3'b000) begin
      errors++; $display("FAIL reset_acks: got %b required 000", {if_ack, dm_ack, err});
    end
    checks++;
    if ({if_rdata, dm_rdata} !== '0) begin
      errors++; $display("FAIL reset_rdata: got %h required 0", {if_rdata, dm_rdata});
    end
    checks++;
    if ({if_stall, dm_stall} !== 2'b00) begin
      errors++; $display("FAIL reset_stall: got %b required 00", {if_stall, dm_stall});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_fetch();
    int   ack_idx = -1;
    int   req_cycles = 0;
    int   stall_cycles = 0;
    logic we_seen = 1'b1;
    mem_wait = 0;
    grant_q.delete();
    @(posedge clk); #1;
    if_addr = 32'h0000_0100;
    if_req  = 1'b1;
    exp_if_q.push_back({1'b0, 32'hDEAD_BEEF});
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mem_req) begin
        req_cycles++;
        we_seen = mem_we;
      end
      if (if_stall) stall_cycles++;
      if (if_ack && ack_idx < 0) begin
        ack_idx = i;
        if_req  = 1'b0;
      end
    end
    if_req = 1'b0;
    checks++;
    if (ack_idx != 2) begin
      errors++; $display("FAIL fetch_ack_latency: got %0d required 2", ack_idx);
    end
    checks++;
    if (req_cycles != 1 || we_seen !== 1'b0) begin
      errors++; $display("FAIL fetch_mem_req: got cycles=%0d we=%b required cycles=1 we=0",
                         req_cycles, we_seen);
    end
    checks++;
    if (stall_cycles != 2) begin
      errors++; $display("FAIL fetch_stall: got %0d required 2", stall_cycles);
    end
  endtask

  task automatic test_store_wait();
    int req_cycles = 0;
    int stall_cycles = 0;
    int acks = 0;
    logic [1+AW+XLEN+XLEN/8-1:0] first_fields = '0;
    mem_wait = 3;
    @(posedge clk); #1;
    dm_we    = 1'b1;
    dm_addr  = 32'h0000_0200;
    dm_wdata = 32'h1234_5678;
    dm_wstrb = 4'hF;
    dm_req   = 1'b1;
    exp_dm_q.push_back({1'b0, 32'h0000_0000});
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (mem_req) begin
        req_cycles++;
        if (req_cycles == 1) first_fields = {mem_we, mem_addr, mem_wdata, mem_wstrb};
      end
      if (dm_stall) stall_cycles++;
      if (dm_ack) begin
        acks++;
        dm_req = 1'b0;
      end
    end
    dm_req = 1'b0;
    dm_we  = 1'b0;
    checks++;
    if (req_cycles != 4) begin
      errors++; $display("FAIL store_busy_cycles: got %0d required 4", req_cycles);
    end
    checks++;
    if (stall_cycles != 5) begin
      errors++; $display("FAIL store_stall: got %0d required 5", stall_cycles);
    end
    checks++;
    if (acks != 1) begin
      errors++; $display("FAIL store_ack_count: got %0d required 1", acks);
    end
    checks++;
    if (first_fields !== {1'b1, 32'h0000_0200, 32'h1234_5678, 4'hF}) begin
      errors++; $display("FAIL store_fields: got %h required %h", first_fields,
                         {1'b1, 32'h0000_0200, 32'h1234_5678, 4'hF});
    end
    mem_wait = 0;
  endtask

  task automatic test_simultaneous();
    bit   done_if = 1'b0;
    bit   done_dm = 1'b0;
    logic prev_req = 1'b0;
    int   req_runs = 0;
    mem_wait = 1;
    grant_q.delete();
    @(posedge clk); #1;
    if_addr  = 32'h0000_0140;
    dm_addr  = 32'h0000_0240;
    dm_we    = 1'b0;
    dm_wstrb = 4'h0;
    if_req   = 1'b1;
    dm_req   = 1'b1;
    exp_if_q.push_back({1'b0, rd_of(32'h0000_0140)});
    exp_dm_q.push_back({1'b0, rd_of(32'h0000_0240)});
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (mem_req && !prev_req) req_runs++;
      prev_req = mem_req;
      if (if_ack) begin if_req = 1'b0; done_if = 1'b1; end
      if (dm_ack) begin dm_req = 1'b0; done_dm = 1'b1; end
      if (done_if && done_dm) break;
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    checks++;
    if (!(done_if && done_dm)) begin
      errors++; $display("FAIL simul_done: got if=%b dm=%b required 1 1", done_if, done_dm);
    end
    checks++;
    if (grant_q.size() != 2 || grant_q[0] !== 32'h0000_0240 || grant_q[1] !== 32'h0000_0140) begin
      errors++; $display("FAIL simul_order: got %0d grants first=%h required 240 then 140",
                         grant_q.size(), (grant_q.size() > 0) ? grant_q[0] : 32'h0);
    end
    checks++;
    if (req_runs != 2) begin
      errors++; $display("FAIL simul_no_overlap: got %0d req runs required 2", req_runs);
    end
    mem_wait = 0;
  endtask

  task automatic test_starvation();
    logic [AW-1:0] exp_order [7] = '{32'h300, 32'h304, 32'h308, 32'h30C,
                                     32'h180, 32'h310, 32'h180};
    int dm_cnt = 0;
    int if_cnt = 0;
    logic [1:0] streak_seen = 2'b11;
    logic [AW-1:0] a;
    mem_wait = 0;
    grant_q.delete();
    @(posedge clk); #1;
    if_addr  = 32'h0000_0180;
    dm_addr  = 32'h0000_0300;
    dm_we    = 1'b0;
    if_req   = 1'b1;
    dm_req   = 1'b1;
    exp_if_q.push_back({1'b0, rd_of(32'h0000_0180)});
    exp_dm_q.push_back({1'b0, rd_of(32'h0000_0300)});
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (dm_ack) begin
        dm_cnt++;
        if (dm_cnt < 5) begin
          a = 32'h0000_0300 + 32'(4 * dm_cnt);
          dm_addr = a;
          exp_dm_q.push_back({1'b0, rd_of(a)});
        end else begin
          dm_req = 1'b0;
        end
      end
      if (if_ack) begin
        if_cnt++;
        if (if_cnt == 1) begin
          streak_seen = dut.streak_r[1:0];
          checks++;
          if (dut.streak_r !== '0) begin
            errors++; $display("FAIL streak_after_if: got %0d required 0", dut.streak_r);
          end
          exp_if_q.push_back({1'b0, rd_of(32'h0000_0180)});
        end else begin
          if_req = 1'b0;
        end
      end
      if (dm_cnt == 5 && if_cnt == 2) break;
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    checks++;
    if (grant_q.size() != 7) begin
      errors++; $display("FAIL starve_grant_count: got %0d required 7", grant_q.size());
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (grant_q.size() <= i || grant_q[i] !== exp_order[i]) begin
        errors++; $display("FAIL starve_order[%0d]: got %h required %h", i,
                           (grant_q.size() > i) ? grant_q[i] : 32'hFFFF_FFFF, exp_order[i]);
      end
    end
    if (streak_seen == 2'b11) $display("note: starvation fetch ack not observed");
  endtask

  task automatic test_reset_mid();
    bit         seen = 1'b0;
    int         acks = 0;
    bit         got_fetch = 1'b0;
    logic [1:0] st;
    mem_hang = 1'b1;
    @(posedge clk); #1;
    dm_we    = 1'b1;
    dm_addr  = 32'h0000_02F0;
    dm_wdata = 32'hCAFE_F00D;
    dm_wstrb = 4'h3;
    dm_req   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_req) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL rstmid_granted: got no mem_req required granted");
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++; $display("FAIL rstmid_req_drop: got %b required 0", mem_req);
    end
    dm_req = 1'b0;
    dm_we  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (dm_ack) acks++;
    end
    rst_n    = 1'b1;
    mem_hang = 1'b0;
    @(negedge clk);
    if (dm_ack) acks++;
    st = dut.state_r;
    checks++;
    if (st !== 2'd0) begin
      errors++; $display("FAIL rstmid_idle: got state %0d required 0", st);
    end
    checks++;
    if (acks != 0) begin
      errors++; $display("FAIL rstmid_no_ack: got %0d acks required 0", acks);
    end
    if_addr = 32'h0000_01C0;
    if_req  = 1'b1;
    exp_if_q.push_back({1'b0, rd_of(32'h0000_01C0)});
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (if_ack) begin got_fetch = 1'b1; if_req = 1'b0; break; end
    end
    if_req = 1'b0;
    checks++;
    if (!got_fetch) begin
      errors++; $display("FAIL rstmid_recover: got no fetch ack required ack");
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int g;
    int ack_at;
    for (int k = 0; k < 2; k++) begin
      g      = -1;
      ack_at = -1;
      mem_hang = (k == 0);
      mem_wait = 7;
      @(posedge clk); #1;
      if_addr = (k == 0) ? 32'h0000_01E0 : 32'h0000_01E4;
      if_req  = 1'b1;
      if (k == 0) exp_if_q.push_back({1'b1, 32'h0000_0000});
      else        exp_if_q.push_back({1'b0, rd_of(32'h0000_01E4)});
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (mem_req && g < 0) g = i;
        if (if_ack) begin ack_at = i - g; if_req = 1'b0; break; end
      end
      if_req = 1'b0;
      checks++;
      if (g < 0 || ack_at != 8) begin
        errors++; $display("FAIL timeout_latency[%0d]: got %0d required 8", k, ack_at);
      end
    end
    mem_hang = 1'b0;
    mem_wait = 0;
  endtask
`endif

  initial begin
    rst_n    = 1'b1;
    if_req   = 1'b0;
    if_addr  = '0;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    dm_addr  = '0;
    dm_wdata = '0;
    dm_wstrb = '0;
    test_reset();
    test_single_fetch();
    test_store_wait();
    test_simultaneous();
    test_starvation();
    test_reset_mid();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (exp_if_q.size() != 0 || exp_dm_q.size() != 0) begin
      errors++; $display("FAIL pending_responses: got if=%0d dm=%0d required 0 0",
                         exp_if_q.size(), exp_dm_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
